// File: rtl/masked_theta_scheduler_pkg.sv
// Shared types and GF(2^2) helpers for the masked theta scheduler.
// bv2_t/bv4_t are GF(2^2)/GF(2^4) nibbles; a bv4_t is {hi, lo} over GF(2^2)
// with polynomial basis x^2+x+1 and tower constant N = x.
package masked_theta_scheduler_pkg;

   typedef logic [1:0] bv2_t;
   typedef logic [3:0] bv4_t;

   // number of unordered share pairs; each pair draws 4 fresh random bits
   function automatic int num_quad(int n);
      return n * (n - 1) / 2;
   endfunction

   localparam int THETA_RES_DEPTH   = 2;
   localparam int THETA_DEF_SHARES  = 2;
   localparam int THETA_DEF_REQ     = 4;

   typedef struct packed {
      logic [$clog2(THETA_DEF_REQ)-1:0] id;
      bv2_t [THETA_DEF_SHARES-1:0]      shares;
   } theta_res_t;

   // GF(2^2) multiply, x^2 = x + 1
   function automatic bv2_t gf4_mul(bv2_t a, bv2_t b);
      return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
              (a[1] & b[1]) ^ (a[0] & b[0])};
   endfunction

   // GF(2^2) square (linear over GF(2))
   function automatic bv2_t gf4_sq(bv2_t a);
      return {a[1], a[1] ^ a[0]};
   endfunction

   // N * a^2 with N = x; collapses to a bit swap
   function automatic bv2_t gf4_scl_sq(bv2_t a);
      return {a[0], a[1]};
   endfunction

endpackage

// File: rtl/masked_theta_scheduler_if.sv
// Requester / randomness / result bus of the masked theta scheduler.
interface masked_theta_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_SHARES = 2
);
   import masked_theta_scheduler_pkg::*;

   localparam int NUM_RANDOM = 4 * num_quad(NUM_SHARES);
   localparam int ID_W       = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]                   in_req_valid;
   logic [NUM_REQ-1:0]                   out_req_ready;
   bv4_t [NUM_REQ-1:0][NUM_SHARES-1:0]   in_req_data;
   logic                                 in_rand_valid;
   logic                                 out_rand_ready;
   logic [NUM_RANDOM-1:0]                in_rand;
   logic                                 out_res_valid;
   logic                                 in_res_ready;
   logic [ID_W-1:0]                      out_res_id;
   bv2_t [NUM_SHARES-1:0]                out_res_data;
   logic                                 out_busy;

   modport slave (
      input  in_req_valid, in_req_data, in_rand_valid, in_rand, in_res_ready,
      output out_req_ready, out_rand_ready, out_res_valid, out_res_id,
             out_res_data, out_busy
   );

   modport master (
      output in_req_valid, in_req_data, in_rand_valid, in_rand, in_res_ready,
      input  out_req_ready, out_rand_ready, out_res_valid, out_res_id,
             out_res_data, out_busy
   );

endinterface

// File: rtl/masked_bv4_comp_theta.sv
// Masked theta = N*h^2 ^ h*l ^ l^2 of a shared GF(2^4) value {h,l}.
// Domain-oriented masking: cross-domain products are refreshed and
// registered before the per-share compression, giving one cycle latency.
module masked_bv4_comp_theta
   import masked_theta_scheduler_pkg::*;
#(
   parameter  int NUM_SHARES = 2,
   localparam int NUM_RANDOM = 4 * num_quad(NUM_SHARES)
) (
   input  logic                    clk,
   input  bv4_t [NUM_SHARES-1:0]   in_a,
   input  logic [NUM_RANDOM-1:0]   in_rand,
   output bv2_t [NUM_SHARES-1:0]   out_theta
);

   bv2_t [NUM_SHARES-1:0][NUM_SHARES-1:0] term_d, term_q;

   // index of unordered pair (i<j) into the randomness vector
   function automatic int pair_idx(int i, int j);
      return i * NUM_SHARES - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   // per-domain terms; each pair's low random bits refresh its two cross
   // products, the high bits re-mask both diagonals and cancel on recombine
   always_comb begin
      term_d = '0;
      for (int i = 0; i < NUM_SHARES; i++) begin
         for (int j = 0; j < NUM_SHARES; j++) begin
            term_d[i][j] = gf4_mul(in_a[i][3:2], in_a[j][1:0]);
         end
         term_d[i][i] = term_d[i][i] ^ gf4_scl_sq(in_a[i][3:2]) ^ gf4_sq(in_a[i][1:0]);
      end
      for (int i = 0; i < NUM_SHARES; i++) begin
         for (int j = i + 1; j < NUM_SHARES; j++) begin
            term_d[i][j] = term_d[i][j] ^ in_rand[4*pair_idx(i, j) +: 2];
            term_d[j][i] = term_d[j][i] ^ in_rand[4*pair_idx(i, j) +: 2];
            term_d[i][i] = term_d[i][i] ^ in_rand[4*pair_idx(i, j) + 2 +: 2];
            term_d[j][j] = term_d[j][j] ^ in_rand[4*pair_idx(i, j) + 2 +: 2];
         end
      end
   end

   // the single register stage; free-running, no stall
   always_ff @(posedge clk) begin
      term_q <= term_d;
   end

   // compress each domain's registered terms into its output share
   always_comb begin
      out_theta = '0;
      for (int i = 0; i < NUM_SHARES; i++) begin
         for (int j = 0; j < NUM_SHARES; j++) begin
            out_theta[i] = out_theta[i] ^ term_q[i][j];
         end
      end
   end

endmodule

// File: rtl/masked_theta_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping; the pointer moves past the grant only when advance is high.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [ID_W-1:0]    grant_idx
);

   logic [ID_W-1:0] ptr_d, ptr_q;

   // wrapped priority search and pointer update
   always_comb begin
      logic            found;
      logic [ID_W-1:0] idx;
      int              j;
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      j         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         idx = ID_W'(j);
         if (!found && req[idx]) begin
            found         = 1'b1;
            grant_idx     = idx;
            grant_oh[idx] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (advance) ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
   end

   // pointer register
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/masked_theta_scheduler.sv
// Shares one masked theta unit among NUM_REQ requesters. Round-robin issue,
// gated on fresh randomness and on a credit that counts the in-flight op
// against the 2-entry result FIFO, so the non-stalling datapath never
// overflows it.
// Optional: THETA_SCHED_ZERO_IDLE_EN zeroes theta inputs in idle cycles and
// clears FIFO entries on pop; port behaviour is unchanged.
module masked_theta_scheduler
   import masked_theta_scheduler_pkg::*;
#(
   parameter int NUM_SHARES = 2,
   parameter int NUM_REQ    = 4
) (
   input logic                     in_clock,
   input logic                     in_reset,
   masked_theta_scheduler_if.slave bus
);

   localparam int NUM_RANDOM = 4 * num_quad(NUM_SHARES);
   localparam int ID_W       = $clog2(NUM_REQ);

   typedef struct packed {
      logic [ID_W-1:0]       id;
      bv2_t [NUM_SHARES-1:0] shares;
   } res_t;

   res_t [THETA_RES_DEPTH-1:0] fifo_d, fifo_q;
   logic            rd_ptr_d, rd_ptr_q, wr_ptr_d, wr_ptr_q;
   logic [1:0]      cnt_d, cnt_q, occ_after;
   logic [2:0]      load;
   logic            inflight_d, inflight_q;
   logic [ID_W-1:0] inflight_id_d, inflight_id_q;
   logic            pop, push, credit, issue;
   logic [NUM_REQ-1:0]    grant_oh;
   logic [ID_W-1:0]       grant_idx;
   bv4_t [NUM_SHARES-1:0] theta_a;
   logic [NUM_RANDOM-1:0] theta_r;
   bv2_t [NUM_SHARES-1:0] theta_y;

   // credit check: an issue is allowed only if its result will find room
   always_comb begin
      pop       = (cnt_q != 2'd0) & bus.in_res_ready;
      occ_after = cnt_q - {1'b0, pop};
      load      = {1'b0, occ_after} + {2'b00, inflight_q};
      credit    = load < 3'd2;
      issue     = (|bus.in_req_valid) & bus.in_rand_valid & credit & ~in_reset;
      push      = inflight_q;
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (in_clock),
      .rst       (in_reset),
      .req       (bus.in_req_valid),
      .advance   (issue),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx)
   );

`ifdef THETA_SCHED_ZERO_IDLE_EN
   // idle cycles feed zeros so no stale masked data toggles the multiplier
   always_comb begin
      theta_a = '0;
      theta_r = '0;
      if (issue) begin
         theta_a = bus.in_req_data[grant_idx];
         theta_r = bus.in_rand;
      end
   end
`else
   bv4_t [NUM_SHARES-1:0] op_d, op_q;
   logic [NUM_RANDOM-1:0] rnd_d, rnd_q;

   // idle cycles replay the last issued operands
   always_comb begin
      op_d  = op_q;
      rnd_d = rnd_q;
      if (issue) begin
         op_d  = bus.in_req_data[grant_idx];
         rnd_d = bus.in_rand;
      end
      theta_a = op_d;
      theta_r = rnd_d;
   end

   // operand hold registers
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         op_q  <= '0;
         rnd_q <= '0;
      end else begin
         op_q  <= op_d;
         rnd_q <= rnd_d;
      end
   end
`endif

   masked_bv4_comp_theta #(.NUM_SHARES(NUM_SHARES)) u_theta (
      .clk       (in_clock),
      .in_a      (theta_a),
      .in_rand   (theta_r),
      .out_theta (theta_y)
   );

   // FIFO bookkeeping and in-flight tag; a push into the slot being popped wins
   always_comb begin
      fifo_d        = fifo_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if (pop) begin
`ifdef THETA_SCHED_ZERO_IDLE_EN
         fifo_d[rd_ptr_q] = '0;
`endif
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
         fifo_d[wr_ptr_q].id     = inflight_id_q;
         fifo_d[wr_ptr_q].shares = theta_y;
         wr_ptr_d                = ~wr_ptr_q;
      end
      cnt_d         = cnt_q + {1'b0, push} - {1'b0, pop};
      inflight_d    = issue;
      inflight_id_d = issue ? grant_idx : inflight_id_q;
   end

   // state registers
   always_ff @(posedge in_clock) begin
      if (in_reset) begin
         fifo_q        <= '0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         cnt_q         <= 2'd0;
         inflight_q    <= 1'b0;
         inflight_id_q <= '0;
      end else begin
         fifo_q        <= fifo_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         cnt_q         <= cnt_d;
         inflight_q    <= inflight_d;
         inflight_id_q <= inflight_id_d;
      end
   end

   assign bus.out_req_ready  = issue ? grant_oh : '0;
   assign bus.out_rand_ready = issue;
   assign bus.out_res_valid  = cnt_q != 2'd0;
   assign bus.out_res_id     = bus.out_res_valid ? fifo_q[rd_ptr_q].id : '0;
   assign bus.out_res_data   = bus.out_res_valid ? fifo_q[rd_ptr_q].shares : '0;
   assign bus.out_busy       = inflight_q | bus.out_res_valid;

   // a push must always find a free slot
   a_no_overflow: assert property (@(posedge in_clock) disable iff (in_reset)
                                   push |-> (occ_after != 2'd2));

endmodule
